rx_ctrl: RTL
============

Name: rx_ctrl

Overview:
- UART receive controller: the receive-side counterpart of the TX path.
- Oversamples the serial input on a tick, frames start, data, optional parity and stop bits, and takes a 3-sample majority vote per bit.
- Pushes each good byte into the RX write port of a uart_fifo.
- Sits between the rxd pin and the RX FIFO; reports framing, parity, overrun and break events to status logic.

Parameters:
- OSR, 16, oversample ticks per bit; even, 8..32.
- DATA_BITS, 8, data bits per frame, LSB first; 5..8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  receiver enable; low forces IDLE synchronously
- tick  in  1  one-clk pulse at OSR x baud rate
- rxd  in  1  asynchronous serial input, idles high
- rx_fifo_full  in  1  RX FIFO write-side full
- rx_fifo_wen  out  1  FIFO write strobe, one clk
- rx_fifo_wdata  out  DATA_BITS  received byte; zero-extend externally to 8
- rx_work  out  1  high whenever state != IDLE
- frame_err  out  1  one-clk pulse, stop bit sampled 0
- par_err  out  1  one-clk pulse, parity mismatch
- ovr_err  out  1  one-clk pulse, byte dropped because FIFO full
- brk_det  out  1  one-clk pulse, break detected

Behaviour:
- Reset: all outputs 0; rxd synchroniser flops reset to 1; state IDLE; counters 0; shift register 0.
- rxd passes a 2-flop synchroniser (rxs). All state advance is gated by tick, except en clear and the output pulses.
- Sample counter scnt runs 0..OSR-1 on ticks. Samples are taken at scnt = OSR/2-1, OSR/2 and OSR/2+1. The majority vote is valid on the tick where scnt = OSR/2+1.
- IDLE: on tick with rxs == 0 -> START, scnt = 0.
- START: if the vote is 1, it is a false start -> IDLE, with no output and no error. Otherwise at scnt = OSR-1 -> DATA, bcnt = 0.
- DATA: the vote shifts into the MSB of the shift register, which shifts right (LSB first). At scnt = OSR-1:
  - if bcnt == DATA_BITS-1 -> PARITY, or STOP when PARITY == 0;
  - else bcnt++.
- PARITY: at the vote, compute perr:
  - even: perr = XOR(data, pbit) != 0;
  - odd: perr = XOR(data, pbit) != 1.
  - At scnt = OSR-1 -> STOP.
- STOP: act at the vote tick itself, not at the end of the bit, so the next start edge can be caught early.
  - vote = 1 -> IDLE.
  - vote = 0 -> BRKWAIT.
- Stop-vote outcomes, registered, asserted on the clk after the stop-vote tick:
  - stop = 1, FIFO not full -> rx_fifo_wen = 1, rx_fifo_wdata = byte, par_err = perr.
  - stop = 1, rx_fifo_full = 1 -> no wen, ovr_err = 1; par_err is still reported.
  - stop = 0 -> byte discarded, no wen.
    - If data == 0 (and parity bit == 0 when enabled) -> brk_det = 1.
    - Otherwise frame_err = 1.
  - Only one of frame_err / brk_det per frame. par_err is not reported on a stop failure.
- BRKWAIT: stay until a tick with rxs == 1, then -> IDLE. A held-low line therefore gives exactly one frame_err or brk_det and never retriggers.
- rx_fifo_wdata holds its value between writes.
- en low: state goes to IDLE on the next clk and counters are cleared. A partial byte is lost with no error and no wen. Any pulse already registered still completes.
- A tick coinciding with en deassertion is ignored.
- Async reset mid-frame: immediate return to the reset values. The first frame after reset needs a full idle-to-start edge.

Decomposition:
- Shared package uart_pkg:
  - state encoding IDLE/START/DATA/PARITY/STOP/BRKWAIT (3 bits);
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - default OSR and DATA_BITS.
- One sub-module, rx_sft:
  - scope: synchroniser, sample counter, majority vote, shift register and bit FSM;
  - outputs: byte, perr and stop-vote strobe/result.
- rx_ctrl keeps the FIFO write, overrun handling and error-pulse logic.

Test Plan:
1. OSR = 16, tick every 4 clk, 8N1, send 0xA5 -> one rx_fifo_wen with rx_fifo_wdata = 0xA5; no error pulses; rx_work falls after the stop vote.
2. rxd low for 5 ticks then high -> false start: no wen, no errors, rx_work high for under 10 ticks and then 0.
3. Send 0x3C with stop = 0, then line high -> frame_err for one clk, no wen; BRKWAIT exits on the first high tick; a following 0x55 is received correctly.
4. Hold rxd low for 20 bit times -> exactly one brk_det, no wen, rx_work high until rxd rises.
5. PARITY = 2, send 0x81 with parity bit 1 -> wen with 0x81 plus par_err. With the correct parity bit 0 -> wen and no par_err.
6. rx_fifo_full = 1, send 0x12 -> ovr_err, no wen. Assert rst low mid-byte of the next frame -> all outputs 0 immediately, the frame is lost, and a later 0x34 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes, defaults.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_BRKWAIT = 3'd5
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DEF_OSR       = 16;
    localparam int DEF_DATA_BITS = 8;

endpackage

// File: rtl/rx_ctrl_if.sv
// RX FIFO write port: the receiver is master, the FIFO is slave.
interface rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);
    logic                 rx_fifo_wen;
    logic [DATA_BITS-1:0] rx_fifo_wdata;
    logic                 rx_fifo_full;

    modport master (output rx_fifo_wen, output rx_fifo_wdata, input rx_fifo_full);
    modport slave  (input rx_fifo_wen, input rx_fifo_wdata, output rx_fifo_full);
endinterface

// File: rtl/rx_sft.sv
// Bit-level receiver: rxd synchroniser, oversample counter, 3-sample
// majority vote, LSB-first shift register and frame FSM.
module rx_sft
    import uart_pkg::*;
#(
    parameter int OSR       = DEF_OSR,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int PARITY    = PAR_NONE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 perr,
    output logic                 frm_zero,
    output logic                 stop_stb,
    output logic                 stop_bit,
    output logic                 busy
);
    localparam int CW = $clog2(OSR);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] SMP0  = CW'(OSR/2 - 1);
    localparam logic [CW-1:0] SMP1  = CW'(OSR/2);
    localparam logic [CW-1:0] SMP2  = CW'(OSR/2 + 1);
    localparam logic [CW-1:0] LAST  = CW'(OSR - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    rx_state_e            st, nxt;
    logic [1:0]           rxs_q;
    logic                 rxs;
    logic [CW-1:0]        scnt;
    logic [BW-1:0]        bcnt;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] sreg;
    logic                 pbit;
    logic                 vote, at_vote, at_end, start_det;

    assign rxs       = rxs_q[1];
    assign vote      = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
    assign at_vote   = (scnt == SMP2);
    assign at_end    = (scnt == LAST);
    assign start_det = (st == S_IDLE) && !rxs;
    assign data      = sreg;

    // Two-flop synchroniser, idles high like the line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rxs_q <= 2'b11;
        else      rxs_q <= {rxs_q[0], rxd};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= S_IDLE;
        else      st <= nxt;
    end

    // Next-state: en low wins, otherwise only ticks advance the frame
    always_comb begin
        nxt = st;
        if (!en) begin
            nxt = S_IDLE;
        end else if (tick) begin
            case (st)
                S_IDLE:    if (!rxs) nxt = S_START;
                S_START:   if (at_vote && vote) nxt = S_IDLE;
                           else if (at_end)     nxt = S_DATA;
                S_DATA:    if (at_end && bcnt == BLAST)
                               nxt = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
                S_PARITY:  if (at_end) nxt = S_STOP;
                // decide mid stop bit so the next start edge is not missed
                S_STOP:    if (at_vote) nxt = vote ? S_IDLE : S_BRKWAIT;
                S_BRKWAIT: if (rxs) nxt = S_IDLE;
                default:   nxt = S_IDLE;
            endcase
        end
    end

    // Counters, vote samples, shift register and parity check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt <= '0;
            bcnt <= '0;
            smp  <= 2'b00;
            sreg <= '0;
            pbit <= 1'b0;
            perr <= 1'b0;
        end else if (!en) begin
            scnt <= '0;
            bcnt <= '0;
        end else if (tick) begin
            if (st == S_IDLE || st == S_BRKWAIT) begin
                // the detecting tick is sample 0 of the start bit
                scnt <= start_det ? CW'(1) : '0;
                if (start_det) begin
                    bcnt <= '0;
                    perr <= 1'b0;
                end
            end else begin
                scnt <= at_end ? '0 : scnt + 1'b1;
                if (scnt == SMP0) smp[0] <= rxs;
                if (scnt == SMP1) smp[1] <= rxs;
                if (st == S_DATA && at_vote) sreg <= {vote, sreg[DATA_BITS-1:1]};
                if (st == S_DATA && at_end && bcnt != BLAST) bcnt <= bcnt + 1'b1;
                if (st == S_PARITY && at_vote) begin
                    pbit <= vote;
                    perr <= (^sreg) ^ vote ^ (PARITY == PAR_ODD);
                end
            end
        end
    end

    // Outputs: busy flag and the stop-vote strobe with its result
    always_comb begin
        busy     = (st != S_IDLE);
        stop_stb = en && tick && (st == S_STOP) && at_vote;
        stop_bit = vote;
        frm_zero = (sreg == '0) && ((PARITY == PAR_NONE) || !pbit);
    end

endmodule

// File: rtl/rx_ctrl.sv
// UART receive controller: turns each stop-bit decision into a FIFO write
// or a one-clk framing / parity / overrun / break pulse.
module rx_ctrl
    import uart_pkg::*;
#(
    parameter int OSR       = DEF_OSR,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int PARITY    = PAR_NONE
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      tick,
    input  logic      rxd,
    rx_ctrl_if.master rx_fifo,
    output logic      rx_work,
    output logic      frame_err,
    output logic      par_err,
    output logic      ovr_err,
    output logic      brk_det
);
    logic [DATA_BITS-1:0] data, wdata_q;
    logic                 perr, frm_zero, stop_stb, stop_bit, busy;
    logic                 wen_q;

    rx_sft #(.OSR(OSR), .DATA_BITS(DATA_BITS), .PARITY(PARITY)) u_sft (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .tick     (tick),
        .rxd      (rxd),
        .data     (data),
        .perr     (perr),
        .frm_zero (frm_zero),
        .stop_stb (stop_stb),
        .stop_bit (stop_bit),
        .busy     (busy)
    );

    assign rx_work               = busy;
    assign rx_fifo.rx_fifo_wen   = wen_q;
    assign rx_fifo.rx_fifo_wdata = wdata_q;

    // One-clk result pulses; write data is held between writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
            ovr_err   <= 1'b0;
            brk_det   <= 1'b0;
        end else begin
            wen_q     <= 1'b0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
            ovr_err   <= 1'b0;
            brk_det   <= 1'b0;
            if (stop_stb) begin
                if (stop_bit) begin
                    if (rx_fifo.rx_fifo_full) begin
                        ovr_err <= 1'b1;
                    end else begin
                        wen_q   <= 1'b1;
                        wdata_q <= data;
                    end
                    par_err <= perr;
                end else if (frm_zero) begin
                    brk_det <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
